// File: rtl/psm_sched_pkg.sv
// Shared types for the PSM beat sequencer.
// FSM state encoding and the quantized-coordinate width helper.
package psm_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILL   = 3'd1,
    ST_TRAIN  = 3'd2,
    ST_SWITCH = 3'd3,
    ST_REF    = 3'd4,
    ST_TEST   = 3'd5,
    ST_DONE   = 3'd6
  } state_e;

  // bits needed to hold a coordinate in 0..l
  function automatic int psm_qw(input int l);
    return $clog2(l + 1);
  endfunction

endpackage

// File: rtl/psm_qdelay.sv
// Quantizer plus TAU-deep delay line of quantized samples.
// Ports: clk, rstn, clr_i, load_i, data_i -> qx_o (x[n]), qy_o (x[n-TAU]).
module psm_qdelay
  import psm_sched_pkg::*;
#(
  parameter int DW      = 16,
  parameter int L       = 6,
  parameter int TAU     = 2,
  parameter int Q_SHIFT = 8,
  parameter int QW      = psm_qw(L)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr_i,
  input  logic          load_i,
  input  logic [DW-1:0] data_i,
  output logic [QW-1:0] qx_o,
  output logic [QW-1:0] qy_o
);

  logic [DW-1:0] sh;
  logic [QW-1:0] dl_q [TAU];

  assign sh   = data_i >> Q_SHIFT;
  assign qx_o = (sh > DW'(L)) ? QW'(L) : sh[QW-1:0];
  // oldest entry is the sample TAU accepts back
  assign qy_o = dl_q[TAU-1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < TAU; i++) dl_q[i] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < TAU; i++) dl_q[i] <= '0;
    end else if (load_i) begin
      dl_q[0] <= qx_o;
      for (int i = 1; i < TAU; i++) dl_q[i] <= dl_q[i-1];
    end
  end

endmodule

// File: rtl/psm_sched.sv
// Beat-level sequencer driving the PSM CPSD datapath through
// fill/train/switch/ref/test phases and returning one CPSD per test beat.
// Inputs: start, abort, beat counts, sample stream (s_*), psm_cpsd.
// Outputs: s_ready, psm_* controls, cpsd_valid/cpsd_data, busy, done.
// Option PSM_SCHED_STATUS_EN adds beat_idx[15:0] and phase[2:0].
module psm_sched
  import psm_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int L          = 6,
  parameter int TAU        = 2,
  parameter int Q_SHIFT    = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  abort,
  input  logic [7:0]            n_train_beats,
  input  logic [7:0]            n_test_beats,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_qrs,
  output logic                  psm_en,
  output logic                  psm_qrs,
  output logic                  psm_test_phase,
  output logic                  psm_cv1_flag,
  output logic [DATA_WIDTH-1:0] psm_vqx,
  output logic [DATA_WIDTH-1:0] psm_vqy,
  input  logic [DATA_WIDTH-1:0] psm_cpsd,
  output logic                  cpsd_valid,
  output logic [DATA_WIDTH-1:0] cpsd_data,
  output logic                  busy,
  output logic                  done
`ifdef PSM_SCHED_STATUS_EN
  ,
  output logic [15:0]           beat_idx,
  output logic [2:0]            phase
`endif
);

  localparam int QW = psm_qw(L);
  localparam int FW = $clog2(TAU + 1);

  state_e          state_q;
  logic            en_q, qrs_q, tp_q, cv1_q;
  logic [QW-1:0]   vqx_q, vqy_q;
  logic            valid_q, done_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [15:0]     beat_q, beat_d;
  logic [7:0]      res_q, res_d;
  logic [7:0]      ntr_q, nte_q;
  logic [FW-1:0]   fill_q, fill_d;
  logic            primed_q;
  // two-stage wait for the PSM to update its CPSD register
  logic [1:0]      pend_q, last_q;

  logic            acc, clr;
  logic [QW-1:0]   qx, qy;

  assign busy    = (state_q != ST_IDLE);
  assign s_ready = busy && (state_q != ST_SWITCH)
                        && (state_q != ST_DONE);
  assign acc     = s_valid && s_ready;
  assign clr     = start && !abort && (state_q == ST_IDLE);

  assign beat_d  = beat_q + 16'd1;
  assign res_d   = res_q + 8'd1;
  assign fill_d  = fill_q + FW'(1);

  psm_qdelay #(
    .DW      (DATA_WIDTH),
    .L       (L),
    .TAU     (TAU),
    .Q_SHIFT (Q_SHIFT),
    .QW      (QW)
  ) u_qdelay (
    .clk    (clk),
    .rstn   (rstn),
    .clr_i  (clr),
    .load_i (acc),
    .data_i (s_data),
    .qx_o   (qx),
    .qy_o   (qy)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      en_q     <= 1'b0;
      qrs_q    <= 1'b0;
      tp_q     <= 1'b0;
      cv1_q    <= 1'b0;
      vqx_q    <= '0;
      vqy_q    <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      data_q   <= '0;
      beat_q   <= '0;
      res_q    <= '0;
      ntr_q    <= '0;
      nte_q    <= '0;
      fill_q   <= '0;
      primed_q <= 1'b0;
      pend_q   <= '0;
      last_q   <= '0;
    end else if (abort) begin
      state_q <= ST_IDLE;
      en_q    <= 1'b0;
      qrs_q   <= 1'b0;
      tp_q    <= 1'b0;
      cv1_q   <= 1'b0;
      vqx_q   <= '0;
      vqy_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      pend_q  <= '0;
      last_q  <= '0;
    end else begin
      en_q    <= 1'b0;
      qrs_q   <= 1'b0;
      tp_q    <= 1'b0;
      cv1_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      pend_q  <= {pend_q[0], 1'b0};
      last_q  <= {last_q[0], 1'b0};

      if (pend_q[1]) begin
        valid_q <= 1'b1;
        data_q  <= psm_cpsd;
        if (last_q[1]) state_q <= ST_DONE;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q  <= ST_FILL;
            beat_q   <= '0;
            res_q    <= '0;
            fill_q   <= '0;
            primed_q <= 1'b0;
            ntr_q    <= (n_train_beats == 8'd0) ? 8'd1 : n_train_beats;
            nte_q    <= (n_test_beats == 8'd0) ? 8'd1 : n_test_beats;
          end
        end
        ST_FILL: begin
          if (acc) begin
            fill_q <= fill_d;
            if (fill_d == FW'(TAU)) state_q <= ST_TRAIN;
          end
        end
        ST_TRAIN: begin
          if (acc) begin
            en_q  <= 1'b1;
            qrs_q <= s_qrs;
            vqx_q <= qx;
            vqy_q <= qy;
            if (s_qrs) begin
              beat_q <= beat_d;
              if (beat_d == {8'd0, ntr_q}) state_q <= ST_SWITCH;
            end
          end
        end
        ST_SWITCH: begin
          // inserted strobe resets the PSM test-phase counter
          en_q    <= 1'b1;
          qrs_q   <= 1'b1;
          tp_q    <= 1'b1;
          state_q <= ST_REF;
        end
        ST_REF: begin
          if (acc) begin
            en_q  <= 1'b1;
            qrs_q <= s_qrs;
            tp_q  <= 1'b1;
            cv1_q <= 1'b1;
            vqx_q <= qx;
            vqy_q <= qy;
            if (s_qrs) begin
              beat_q  <= beat_d;
              state_q <= ST_TEST;
            end
          end
        end
        ST_TEST: begin
          if (acc) begin
            en_q  <= 1'b1;
            qrs_q <= s_qrs;
            tp_q  <= 1'b1;
            vqx_q <= qx;
            vqy_q <= qy;
            if (s_qrs) begin
              beat_q <= beat_d;
              // first test qrs only primes the PSM
              if (!primed_q) begin
                primed_q <= 1'b1;
              end else if (res_q != nte_q) begin
                res_q     <= res_d;
                pend_q[0] <= 1'b1;
                last_q[0] <= (res_d == nte_q);
              end
            end
          end
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
          vqx_q   <= '0;
          vqy_q   <= '0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign psm_en         = en_q;
  assign psm_qrs        = qrs_q;
  assign psm_test_phase = tp_q;
  assign psm_cv1_flag   = cv1_q;
  assign psm_vqx        = {{(DATA_WIDTH-QW){1'b0}}, vqx_q};
  assign psm_vqy        = {{(DATA_WIDTH-QW){1'b0}}, vqy_q};
  assign cpsd_valid     = valid_q;
  assign cpsd_data      = data_q;
  assign done           = done_q;

`ifdef PSM_SCHED_STATUS_EN
  assign beat_idx = beat_q;
  assign phase    = state_q;
`endif

endmodule

// File: tb/tb_psm_sched.sv
// Self-checking bench for psm_sched.
// Transaction-level reference model plus directed scenarios.
module tb_psm_sched;

  localparam int TAU = 2;
  localparam int LQ  = 6;

  localparam int M_IDLE   = 0;
  localparam int M_FILL   = 1;
  localparam int M_TRAIN  = 2;
  localparam int M_SWITCH = 3;
  localparam int M_REF    = 4;
  localparam int M_TEST   = 5;
  localparam int M_DONE   = 6;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  ntr_in = '0;
  logic [7:0]  nte_in = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_data = '0;
  logic        s_qrs = 1'b0;
  logic        psm_en, psm_qrs, psm_test_phase, psm_cv1_flag;
  logic [15:0] psm_vqx, psm_vqy;
  logic [15:0] psm_cpsd = '0;
  logic        cpsd_valid;
  logic [15:0] cpsd_data;
  logic        busy, done;
`ifdef PSM_SCHED_STATUS_EN
  logic [15:0] beat_idx;
  logic [2:0]  phase;
`endif

  psm_sched dut (
    .clk            (clk),
    .rstn           (rstn),
    .start          (start),
    .abort          (abort),
    .n_train_beats  (ntr_in),
    .n_test_beats   (nte_in),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .s_qrs          (s_qrs),
    .psm_en         (psm_en),
    .psm_qrs        (psm_qrs),
    .psm_test_phase (psm_test_phase),
    .psm_cv1_flag   (psm_cv1_flag),
    .psm_vqx        (psm_vqx),
    .psm_vqy        (psm_vqy),
    .psm_cpsd       (psm_cpsd),
    .cpsd_valid     (cpsd_valid),
    .cpsd_data      (cpsd_data),
    .busy           (busy),
    .done           (done)
`ifdef PSM_SCHED_STATUS_EN
    ,
    .beat_idx       (beat_idx),
    .phase          (phase)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int n_valid = 0;
  int n_done = 0;

  typedef struct {
    int t;
    bit last;
  } pend_t;

  int    m_mode, m_fill, m_beats, m_ntr, m_nte, m_sched;
  bit    m_primed;
  int    m_hist [TAU];
  int    cyc;
  pend_t pend [$];

  bit    e_en, e_qrs, e_tp, e_cv1, e_valid, e_done;
  int    e_vqx, e_vqy, e_data;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_ready();
    return m_mode != M_IDLE && m_mode != M_SWITCH && m_mode != M_DONE;
  endfunction

  function automatic int quant(input logic [15:0] d);
    int v;
    v = int'(d >> 8);
    return (v > LQ) ? LQ : v;
  endfunction

  task automatic m_reset();
    m_mode = M_IDLE;
    m_fill = 0; m_beats = 0; m_ntr = 0; m_nte = 0; m_sched = 0;
    m_primed = 0;
    for (int i = 0; i < TAU; i++) m_hist[i] = 0;
    pend.delete();
    e_en = 0; e_qrs = 0; e_tp = 0; e_cv1 = 0;
    e_valid = 0; e_done = 0;
    e_vqx = 0; e_vqy = 0; e_data = 0;
  endtask

  // push a sample into the model history, returning x[n-TAU]
  task automatic m_push(input int q, output int old);
    old = m_hist[TAU-1];
    for (int i = TAU - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = q;
  endtask

  task automatic m_issue(input int q, input bit tp, input bit cv1);
    int old;
    m_push(q, old);
    e_en = 1; e_qrs = s_qrs; e_tp = tp; e_cv1 = cv1;
    e_vqx = q; e_vqy = old;
  endtask

  task automatic m_step();
    bit acc;
    int q, old;
    acc = s_valid && m_ready();
    q = quant(s_data);
    e_en = 0; e_qrs = 0; e_tp = 0; e_cv1 = 0;
    e_valid = 0; e_done = 0;
    if (abort) begin
      m_mode = M_IDLE;
      e_vqx = 0; e_vqy = 0;
      pend.delete();
    end else begin
      case (m_mode)
        M_IDLE: if (start) begin
          m_mode = M_FILL;
          for (int i = 0; i < TAU; i++) m_hist[i] = 0;
          m_fill = 0; m_beats = 0; m_sched = 0; m_primed = 0;
          m_ntr = (ntr_in == 0) ? 1 : int'(ntr_in);
          m_nte = (nte_in == 0) ? 1 : int'(nte_in);
        end
        M_FILL: if (acc) begin
          m_push(q, old);
          m_fill++;
          if (m_fill == TAU) m_mode = M_TRAIN;
        end
        M_TRAIN: if (acc) begin
          m_issue(q, 0, 0);
          if (s_qrs) begin
            m_beats++;
            if (m_beats == m_ntr) m_mode = M_SWITCH;
          end
        end
        M_SWITCH: begin
          e_en = 1; e_qrs = 1; e_tp = 1; e_cv1 = 0;
          m_mode = M_REF;
        end
        M_REF: if (acc) begin
          m_issue(q, 1, 1);
          if (s_qrs) begin
            m_beats++;
            m_mode = M_TEST;
          end
        end
        M_TEST: if (acc) begin
          m_issue(q, 1, 0);
          if (s_qrs) begin
            m_beats++;
            if (!m_primed) m_primed = 1;
            else if (m_sched < m_nte) begin
              m_sched++;
              pend.push_back('{t: cyc + 2, last: (m_sched == m_nte)});
            end
          end
        end
        M_DONE: begin
          e_done = 1;
          m_mode = M_IDLE;
          e_vqx = 0; e_vqy = 0;
        end
        default: m_mode = M_IDLE;
      endcase
      if (pend.size() > 0 && pend[0].t == cyc) begin
        e_valid = 1;
        e_data = int'(psm_cpsd);
        if (pend[0].last) m_mode = M_DONE;
        void'(pend.pop_front());
      end
    end
    cyc++;
  endtask

  task automatic check_all();
    chk("s_ready", s_ready, m_ready());
    chk("busy", busy, m_mode != M_IDLE);
    chk("psm_en", psm_en, e_en);
    chk("psm_qrs", psm_qrs, e_qrs);
    chk("test_phase", psm_test_phase, e_tp);
    chk("cv1_flag", psm_cv1_flag, e_cv1);
    chk("vqx", psm_vqx, e_vqx);
    chk("vqy", psm_vqy, e_vqy);
    chk("cpsd_valid", cpsd_valid, e_valid);
    chk("cpsd_data", cpsd_data, e_data);
    chk("done", done, e_done);
  endtask

  task automatic tick();
    @(posedge clk);
    m_step();
    #1;
    check_all();
    n_valid += int'(cpsd_valid);
    n_done += int'(done);
  endtask

  task automatic drive(input bit v, input logic [15:0] d, input bit q);
    s_valid = v; s_data = d; s_qrs = q;
    tick();
  endtask

  task automatic begin_session(input int tr, input int te,
                               input logic [15:0] cp);
    ntr_in = 8'(tr); nte_in = 8'(te); psm_cpsd = cp;
    s_valid = 0; s_qrs = 0;
    start = 1;
    tick();
    start = 0;
    n_valid = 0; n_done = 0;
  endtask

  task automatic run_random(input int budget, input int pv,
                            input bit stop_test);
    bit fin;
    fin = 0;
    for (int i = 0; i < budget && !fin; i++) begin
      if (m_mode == M_IDLE) fin = 1;
      else if (stop_test && m_mode == M_TEST && pend.size() > 0) fin = 1;
      else begin
        s_valid = ($urandom_range(99) < pv);
        s_data = 16'($urandom_range(0, 16'h0a00));
        s_qrs = ($urandom_range(3) == 0);
        start = ($urandom_range(15) == 0);
        tick();
        start = 0;
      end
    end
    start = 0; s_valid = 0; s_qrs = 0;
    if (!fin) begin
      tests++; fails++;
      $error("FAIL timeout observed=mode%0d expected=goal", m_mode);
    end
  endtask

  initial begin
    int nv0;
    m_reset();
    cyc = 0;

    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("rst_busy", busy, 0);
    rstn = 1;

    // quantize / delay, then finish the session randomly
    begin_session(2, 3, 16'd5);
    drive(1, 16'h0000, 0);
    chk("fill0_en", psm_en, 0);
    drive(1, 16'h0100, 0);
    chk("fill1_en", psm_en, 0);
    drive(1, 16'h0300, 0);
    chk("q3_en", psm_en, 1);
    chk("q3_vqx", psm_vqx, 3);
    chk("q3_vqy", psm_vqy, 0);
    drive(1, 16'h0900, 0);
    chk("q4_vqx", psm_vqx, 6);
    chk("q4_vqy", psm_vqy, 1);
    run_random(3000, 70, 0);
    chk("s1_results", n_valid, 3);
    chk("s1_done", n_done, 1);
    chk("s1_idle", busy, 0);

    // zero counts treated as one
    begin_session(0, 0, 16'($urandom));
    run_random(3000, 60, 0);
    chk("s2_results", n_valid, 1);
    chk("s2_done", n_done, 1);

    begin_session(3, 4, 16'($urandom));
    run_random(4000, 50, 0);
    chk("s3_results", n_valid, 4);
    chk("s3_done", n_done, 1);

    // valid toggling: psm_en mirrors accepted samples
    begin_session(2, 2, 16'd7);
    drive(1, 16'h0200, 0);
    drive(1, 16'h0400, 0);
    drive(1, 16'h0100, 0);
    chk("tog0", psm_en, 1);
    drive(0, 16'h0500, 0);
    chk("tog1", psm_en, 0);
    drive(1, 16'h0500, 0);
    chk("tog2", psm_en, 1);
    drive(1, 16'h0600, 0);
    chk("tog3", psm_en, 1);
    drive(0, 16'h0000, 0);
    chk("tog4", psm_en, 0);
    abort = 1;
    tick();
    abort = 0;
    chk("tog_abort", busy, 0);

    // abort together with start in TEST
    begin_session(1, 3, 16'd9);
    run_random(3000, 70, 1);
    s_valid = 0;
    abort = 1; start = 1;
    tick();
    abort = 0; start = 0;
    chk("abort_busy", busy, 0);
    nv0 = n_valid;
    repeat (6) tick();
    chk("abort_noval", n_valid - nv0, 0);

    // reset mid-TEST
    begin_session(2, 5, 16'd3);
    run_random(3000, 80, 1);
    rstn = 0;
    m_reset();
    #2;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    chk("rst_ready", s_ready, 0);
    rstn = 1;
    repeat (2) tick();

    begin_session(1, 2, 16'($urandom));
    run_random(3000, 90, 0);
    chk("s6_results", n_valid, 2);
    chk("s6_done", n_done, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
